// File: rtl/psg_multi.sv
// psg_multi: multi-channel tone/noise sound generator with ring modulation,
// saturating stereo mixer and per-channel zero interrupts on the Z80 I/O bus.
module psg_multi #(
  parameter int CHANNELS = 3,
  parameter int PERIOD_W = 12,
  parameter int LEVEL_W = 6,
  parameter int OUT_W = 9,
  parameter logic [1:0] BASE = 2'b10,
  parameter int NDIV = 16
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                cecpu,
  input  logic                ceaud,
  input  logic                iorq,
  input  logic                wr,
  input  logic [7:0]          a,
  input  logic [7:0]          d,
  output logic [CHANNELS-1:0] irq,
  output logic [OUT_W-1:0]    l,
  output logic [OUT_W-1:0]    r
);
  localparam int DIV_W = NDIV > 1 ? $clog2(NDIV) : 1;
  localparam int SUM_W = OUT_W > LEVEL_W + 3 ? OUT_W : LEVEL_W + 3;
  localparam logic [SUM_W-1:0] MAX_OUT = SUM_W'({OUT_W{1'b1}});
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(NDIV - 1);
  localparam logic [2:0] LAST_CH = 3'(CHANNELS - 1);

  logic [PERIOD_W-1:0] period [CHANNELS];
  logic [PERIOD_W-1:0] count [CHANNELS];
  logic [1:0] poly [CHANNELS];
  logic [LEVEL_W-1:0] lvlL [CHANNELS];
  logic [LEVEL_W-1:0] lvlR [CHANNELS];
  logic [CHANNELS-1:0] sync, ring, tone, out, z, pre, nbr;
  logic [1:0] nSrc, nTaps;
  logic nSwap, nRing, nout, lDac, rDac, nPre, fb17, nTick, we;
  logic [LEVEL_W-1:0] nLvlL, nLvlR;
  logic [3:0] lfsr4;
  logic [4:0] lfsr5;
  logic [16:0] lfsr17;
  logic [6:0] lfsr7;
  logic [DIV_W-1:0] div;
  logic [2:0] ch, idx, srcCh;
  logic [7:0] zx;
  logic [SUM_W-1:0] sumL, sumR;

  assign we = cecpu && !iorq && !wr && a[7:6] == BASE;
  assign ch = a[5:3];
  assign idx = a[2:0];
  assign nbr = (out << 1) | (out >> (CHANNELS - 1));
  assign zx = 8'(z);
  assign srcCh = {1'b0, nSrc} - 3'd1 > LAST_CH ? LAST_CH : {1'b0, nSrc} - 3'd1;
  assign nTick = nSrc == 2'd0 ? ceaud && div == DIV_LAST : zx[srcCh];
  assign nPre = nSwap ? lfsr7[0] : lfsr17[0];
  assign fb17 = nTaps == 2'd0 ? lfsr17[16] ^ lfsr17[13] :
                nTaps == 2'd1 ? lfsr17[14] ^ lfsr17[13] :
                nTaps == 2'd2 ? lfsr17[10] ^ lfsr17[8] : lfsr17[8] ^ lfsr17[4];

  // All sources and neighbour bits are the values held before the current clock.
  always_comb begin
    z = '0;
    pre = '0;
    sumL = nout ? SUM_W'(nLvlL) : '0;
    sumR = nout ? SUM_W'(nLvlR) : '0;
    for (int k = 0; k < CHANNELS; k++) begin
      z[k] = ceaud && count[k] == '0 && !sync[k];
      pre[k] = poly[k] == 2'd0 ? tone[k] : poly[k] == 2'd1 ? lfsr4[0] : poly[k] == 2'd2 ? lfsr5[0] : nout;
      sumL = sumL + (out[k] ? SUM_W'(lvlL[k]) : '0);
      sumR = sumR + (out[k] ? SUM_W'(lvlR[k]) : '0);
    end
  end

  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      for (int k = 0; k < CHANNELS; k++) begin
        period[k] <= '0;
        count[k] <= '0;
        poly[k] <= '0;
        lvlL[k] <= '0;
        lvlR[k] <= '0;
      end
      {sync, ring, tone, out, irq} <= '0;
      {nSrc, nTaps, nSwap, nRing, nout, lDac, rDac} <= '0;
      {nLvlL, nLvlR} <= '0;
      {lfsr4, lfsr5, lfsr17, lfsr7} <= '1;
      div <= '0;
      l <= '0;
      r <= '0;
    end else begin
      for (int k = 0; k < CHANNELS; k++) begin
        if (we && ch == 3'(k)) begin
          if (idx == 3'd0) period[k][7:0] <= d;
          if (idx == 3'd1) period[k][PERIOD_W-1:8] <= d[PERIOD_W-9:0];
          if (idx == 3'd2) {poly[k], ring[k], sync[k]} <= d[3:0];
          if (idx == 3'd3) lvlL[k] <= d[LEVEL_W-1:0];
          if (idx == 3'd4) lvlR[k] <= d[LEVEL_W-1:0];
        end
        if (ceaud) count[k] <= sync[k] || count[k] == '0 ? period[k] : count[k] - 1'b1;
        if (z[k]) out[k] <= ring[k] ? ~(pre[k] ^ nbr[k]) : pre[k];
      end
      if (we && ch == 3'd7) begin
        if (idx == 3'd0) {nRing, nSwap, nTaps, nSrc} <= d[5:0];
        if (idx == 3'd3) nLvlL <= d[LEVEL_W-1:0];
        if (idx == 3'd4) nLvlR <= d[LEVEL_W-1:0];
        if (idx == 3'd5) {rDac, lDac} <= d[1:0];
      end
      tone <= (tone ^ z) & ~sync;
      irq <= z;
      if (ceaud) begin
        lfsr4 <= lfsr4 == '0 ? '1 : {lfsr4[2:0], lfsr4[3] ^ lfsr4[2]};
        lfsr5 <= lfsr5 == '0 ? '1 : {lfsr5[3:0], lfsr5[4] ^ lfsr5[2]};
        div <= div == DIV_LAST ? '0 : div + 1'b1;
      end
      if (nTick) begin
        lfsr17 <= lfsr17 == '0 ? '1 : {lfsr17[15:0], fb17};
        lfsr7 <= lfsr7 == '0 ? '1 : {lfsr7[5:0], lfsr7[6] ^ lfsr7[5]};
        nout <= nRing ? ~(nPre ^ out[0]) : nPre;
      end
      l <= lDac ? OUT_W'(lvlL[0]) : sumL > MAX_OUT ? '1 : OUT_W'(sumL);
      r <= rDac ? OUT_W'(lvlR[0]) : sumR > MAX_OUT ? '1 : OUT_W'(sumR);
    end
endmodule
